alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter MUL_LAT, default 3: EXEC cycles for multiply (ctr 3'b100); legal range 1..15.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  reset; asynchronous, active-low (0 = reset).
REQ-004 a_req_i  input  1  requester A operation request; held high, operands stable, until a_ack_o.
REQ-005 a_ctr_i  input  3  requester A ALU op (000 add, 001 sub, 010 or, 011 and, 100 mul).
REQ-006 a_data1_i / a_data2_i  input  32 each  requester A operands.
REQ-007 b_req_i, b_ctr_i, b_data1_i, b_data2_i  input  1/3/32/32  requester B, same meaning.
REQ-008 a_ack_o / b_ack_o  output  1 each  one-cycle pulse; res_o/err_o valid for that requester.
REQ-009 res_o  output  32  shared result bus.
REQ-010 err_o  output  1  op code was illegal (101..111).
REQ-011 alu_data1_o / alu_data2_o  output  32 each  operands to shared combinational ALU.
REQ-012 alu_ctr_o  output  3  op code to shared ALU.
REQ-013 alu_res_i  input  32  ALU result.
REQ-014 busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-016 IDLE: no request -> stay IDLE; any request -> grant, latch winner's ctr/data1/data2 into internal registers, go EXEC.
REQ-017 Only A requesting -> A wins; only B -> B wins; both -> requester not granted last time wins (round-robin).
REQ-018 Last-grant flag updates only on a grant; after reset it reads B, so A wins first contention.
REQ-019 alu_ctr_o/alu_data1_o/alu_data2_o driven solely from latched registers; stable for whole EXEC, changed only on grant.
REQ-020 EXEC length: 1 cycle for 000..011 and illegal codes; MUL_LAT cycles for 100, via down-counter loaded at grant.
REQ-021 Last EXEC cycle: capture alu_res_i into res_o (legal op) or 0 with err_o=1 (illegal op); err_o=0 for legal op; go RESP.
REQ-022 Captured value = low 32 bits of ALU result (add/sub/mul wrap modulo 2^32, no overflow flag).
REQ-023 RESP: exactly one cycle; granted requester's ack_o=1, other ack_o=0; then IDLE unconditionally.
REQ-024 Latency non-mul: request sampled in IDLE at cycle T -> ack at T+2; mul: ack at T+1+MUL_LAT.
REQ-025 Requesters' req_i ignored outside IDLE; a loser's request stays pending with no side effect.
REQ-026 A req_i still high in IDLE after ack = new request (back-to-back ops allowed, 3-cycle min spacing non-mul).
REQ-027 res_o and err_o hold their values after RESP until next capture.
REQ-028 Operand changes by requester after grant do not affect in-flight result.

Reset
REQ-029 rst_i=0 forces immediately, without clock: state IDLE, a_ack_o=b_ack_o=0, res_o=0, err_o=0, busy_o=0, alu_ctr_o=000, alu_data1_o=alu_data2_o=0, counter=0, last-grant=B.
REQ-030 Reset during EXEC/RESP aborts op: no ack ever issued for it; requester must re-request after release.
REQ-031 First arbitration on first rising edge with rst_i=1.

Verification
REQ-032 A alone, ctr=000, 7+5 at cycle T -> a_ack_o pulse T+2, res_o=12, err_o=0, b_ack_o=0.
REQ-033 A and B both request at T (A: 001 9-4, B: 010 0xF0|0x0F) -> A ack T+2 res 5; B granted T+3, ack T+5 res 0xFF.
REQ-034 MUL_LAT=3, B: 100 0x10000*0x10000 at T -> alu_ctr_o=100 stable T+1..T+3, b_ack_o at T+4, res_o=0 (wrap).
REQ-035 A ctr=110 -> a_ack_o at T+2, res_o=0, err_o=1; next legal op clears err_o.
REQ-036 A and B held high for 4 ops -> grants alternate A,B,A,B; no ack overlaps; busy_o low only in IDLE gaps.
REQ-037 rst_i low mid-EXEC of a mul -> outputs at reset values asynchronously; no ack after release; next request behaves as REQ-032.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational ALU.
// Each operation runs IDLE -> EXEC -> RESP; multiply stays in EXEC for MUL_LAT cycles.
module alu_arbiter #(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        a_req_i,
  input  logic [2:0]  a_ctr_i,
  input  logic [31:0] a_data1_i,
  input  logic [31:0] a_data2_i,
  input  logic        b_req_i,
  input  logic [2:0]  b_ctr_i,
  input  logic [31:0] b_data1_i,
  input  logic [31:0] b_data2_i,
  output logic        a_ack_o,
  output logic        b_ack_o,
  output logic [31:0] res_o,
  output logic        err_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  output logic [2:0]  alu_ctr_o,
  input  logic [31:0] alu_res_i,
  output logic        busy_o
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] OP_MUL   = 3'b100;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);

  logic [1:0]  state_q, state_d;
  logic        last_b_q, last_b_d;
  logic [2:0]  ctr_q, ctr_d;
  logic [31:0] data1_q, data1_d;
  logic [31:0] data2_q, data2_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] res_q, res_d;
  logic        err_q, err_d;
  logic        pick_b;
  logic [2:0]  sel_ctr;
  logic        illegal_op;

  // last_b_q doubles as the owner of the in-flight operation, since it only changes on a grant
  always_comb begin
    state_d    = state_q;
    last_b_d   = last_b_q;
    ctr_d      = ctr_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    err_d      = err_q;
    pick_b     = b_req_i && (!a_req_i || !last_b_q);
    sel_ctr    = pick_b ? b_ctr_i : a_ctr_i;
    illegal_op = (ctr_q > OP_MUL);

    case (state_q)
      IDLE: begin
        if (a_req_i || b_req_i) begin
          state_d  = EXEC;
          last_b_d = pick_b;
          ctr_d    = sel_ctr;
          data1_d  = pick_b ? b_data1_i : a_data1_i;
          data2_d  = pick_b ? b_data2_i : a_data2_i;
          cnt_d    = (sel_ctr == OP_MUL) ? MUL_LOAD : 4'd0;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          res_d   = illegal_op ? 32'd0 : alu_res_i;
          err_d   = illegal_op;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      ctr_q    <= 3'd0;
      data1_q  <= 32'd0;
      data2_q  <= 32'd0;
      cnt_q    <= 4'd0;
      res_q    <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      ctr_q    <= ctr_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      err_q    <= err_d;
    end
  end

  assign a_ack_o     = (state_q == RESP) && !last_b_q;
  assign b_ack_o     = (state_q == RESP) && last_b_q;
  assign busy_o      = (state_q != IDLE);
  assign res_o       = res_q;
  assign err_o       = err_q;
  assign alu_ctr_o   = ctr_q;
  assign alu_data1_o = data1_q;
  assign alu_data2_o = data2_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a behavioural ALU closes the loop, expected
// acks (owner, result, error flag, cycle) are queued at stimulus time and popped on ack.
module tb_alu_arbiter;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req;
  logic [2:0]  a_ctr, b_ctr;
  logic [31:0] a_d1, a_d2, b_d1, b_d2;
  logic        a_ack, b_ack;
  logic [31:0] res;
  logic        err;
  logic [31:0] alu_d1, alu_d2, alu_res;
  logic [2:0]  alu_ctr;
  logic        busy;

  typedef struct {
    logic        is_b;
    logic [31:0] res;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  alu_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .a_req_i(a_req), .a_ctr_i(a_ctr), .a_data1_i(a_d1), .a_data2_i(a_d2),
    .b_req_i(b_req), .b_ctr_i(b_ctr), .b_data1_i(b_d1), .b_data2_i(b_d2),
    .a_ack_o(a_ack), .b_ack_o(b_ack), .res_o(res), .err_o(err),
    .alu_data1_o(alu_d1), .alu_data2_o(alu_d2), .alu_ctr_o(alu_ctr),
    .alu_res_i(alu_res), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU; illegal codes return junk so the arbiter must zero the result itself
  function automatic logic [31:0] alu_model(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    case (c)
      3'b000:  return x + y;
      3'b001:  return x - y;
      3'b010:  return x | y;
      3'b011:  return x & y;
      3'b100:  return x * y;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_res = alu_model(alu_ctr, alu_d1, alu_d2);

  // Scoreboard monitor: every ack must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ((a_ack && b_ack) !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ack_overlap: a_ack=%0b b_ack=%0b, required at most one high", a_ack, b_ack);
      end else if (a_ack || b_ack) begin
        if (sb.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_ack: a_ack=%0b b_ack=%0b at cycle %0d, required no ack", a_ack, b_ack, cyc);
        end else begin
          mon_e = sb.pop_front();
          checks += 3;
          if (b_ack !== mon_e.is_b) begin
            errors++;
            $display("[TB] FAIL ack_owner: b_ack=%0b, required %0b", b_ack, mon_e.is_b);
          end
          if (res !== mon_e.res || err !== mon_e.err) begin
            errors++;
            $display("[TB] FAIL ack_result: res=%h err=%0b, required res=%h err=%0b", res, err, mon_e.res, mon_e.err);
          end
          if (cyc !== mon_e.cyc) begin
            errors++;
            $display("[TB] FAIL ack_cycle: ack at cycle %0d, required %0d", cyc, mon_e.cyc);
          end
        end
      end
    end
  end

  task automatic drive_a(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    a_req = 1'b1; a_ctr = c; a_d1 = x; a_d2 = y;
  endtask

  task automatic drive_b(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    b_req = 1'b1; b_ctr = c; b_d1 = x; b_d2 = y;
  endtask

  task automatic push(input logic is_b, input logic [31:0] r, input logic e, input int c);
    exp_t item;
    item.is_b = is_b; item.res = r; item.err = e; item.cyc = c;
    sb.push_back(item);
  endtask

  // Waits (bounded) for the scoreboard to empty, optionally dropping each request on its ack
  task automatic drain(input int budget, input bit drop, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (drop && a_ack) a_req = 1'b0;
      if (drop && b_ack) b_req = 1'b0;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) sb.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req = 0; a_ctr = 0; a_d1 = 0; a_d2 = 0;
    b_req = 0; b_ctr = 0; b_d1 = 0; b_d2 = 0;
    #1;
    checks++;
    if ({busy, a_ack, b_ack, err, res, alu_ctr, alu_d1, alu_d2} !== 102'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: busy=%0b acks=%0b%0b err=%0b res=%h ctr=%b d1=%h d2=%h, required all zero",
               busy, a_ack, b_ack, err, res, alu_ctr, alu_d1, alu_d2);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_contention();
    bit ok;
    int t;
    @(negedge clk);
    t = cyc;
    drive_a(3'b001, 32'd9, 32'd4);
    drive_b(3'b010, 32'hF0, 32'h0F);
    push(1'b0, 32'd5, 1'b0, t + 2);
    push(1'b1, 32'hFF, 1'b0, t + 5);
    drain(20, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL contention_timeout: acks outstanding, required both served");
    end
  endtask

  task automatic test_single_add();
    bit ok;
    int t;
    @(negedge clk);
    t = cyc;
    drive_a(3'b000, 32'd7, 32'd5);
    push(1'b0, 32'd12, 1'b0, t + 2);
    drain(20, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL add_timeout: ack missing, required a_ack");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (res !== 32'd12 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL result_hold: res=%h err=%0b, required res=0000000c err=0", res, err);
    end
  endtask

  task automatic test_mul();
    bit ok;
    int t;
    @(negedge clk);
    t = cyc;
    drive_b(3'b100, 32'h0001_0000, 32'h0001_0000);
    push(1'b1, 32'd0, 1'b0, t + 1 + MUL_LAT);
    for (int k = 1; k <= MUL_LAT; k++) begin
      @(negedge clk);
      b_d1 = 32'd3; b_d2 = 32'd5;
      checks++;
      if (alu_ctr !== 3'b100 || alu_d1 !== 32'h0001_0000 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL mul_operands: cycle+%0d ctr=%b d1=%h busy=%0b, required ctr=100 d1=00010000 busy=1",
                 k, alu_ctr, alu_d1, busy);
      end
    end
    drain(20, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL mul_timeout: ack missing, required b_ack");
    end
  endtask

  task automatic test_illegal();
    bit ok;
    int t;
    @(negedge clk);
    t = cyc;
    drive_a(3'b110, 32'd1, 32'd2);
    push(1'b0, 32'd0, 1'b1, t + 2);
    drain(20, 1'b1, ok);
    @(negedge clk);
    t = cyc;
    drive_a(3'b000, 32'd1, 32'd2);
    push(1'b0, 32'd3, 1'b0, t + 2);
    drain(20, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL illegal_timeout: ack missing, required a_ack");
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t = cyc;
    drive_a(3'b000, 32'd100, 32'd23);
    drive_b(3'b011, 32'hFF00_FF00, 32'h0F0F_0F0F);
    push(1'b0, 32'd123, 1'b0, t + 2);
    push(1'b1, 32'h0F00_0F00, 1'b0, t + 5);
    push(1'b0, 32'd123, 1'b0, t + 8);
    push(1'b1, 32'h0F00_0F00, 1'b0, t + 11);
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (busy !== ((k % 3) != 0)) begin
        errors++;
        $display("[TB] FAIL b2b_busy: cycle+%0d busy=%0b, required %0b", k, busy, (k % 3) != 0);
      end
      @(negedge clk);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    drain(5, 1'b0, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL b2b_timeout: %0d acks outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid_exec();
    bit ok;
    int t;
    @(negedge clk);
    drive_a(3'b100, 32'd3, 32'd4);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, a_ack, b_ack, err, res, alu_ctr, alu_d1, alu_d2} !== 102'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_exec: busy=%0b acks=%0b%0b err=%0b res=%h ctr=%b d1=%h d2=%h, required all zero",
               busy, a_ack, b_ack, err, res, alu_ctr, alu_d1, alu_d2);
    end
    a_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    t = cyc;
    drive_a(3'b000, 32'd7, 32'd5);
    push(1'b0, 32'd12, 1'b0, t + 2);
    drain(20, 1'b1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL post_reset_timeout: ack missing, required a_ack");
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_add();
    test_mul();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
